// File: rtl/path_gen.sv
// Monte Carlo random-walk price-path source: LFSR-driven steps with clamping, streamed over valid/ready.
// Optional antithetic pairing of even/odd paths is enabled by defining PATH_GEN_ANTITHETIC_EN.
module path_gen #(
    parameter int DATA_W  = 12,
    parameter int SIGMA_W = 6,
    parameter int STEP_W  = 10,
    parameter int PATH_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       seed,
    input  logic [DATA_W-1:0] s0,
    input  logic [7:0]        drift,
    input  logic [PATH_W-1:0] num_paths,
    input  logic [STEP_W-1:0] num_steps,
    output logic [DATA_W-1:0] path,
    output logic              path_valid,
    input  logic              path_ready,
    output logic              path_last,
    output logic              busy,
    output logic              done
);

    // Handshake: a sample transfers on a rising edge where path_valid & path_ready are both high;
    // path and path_last are held unchanged while path_valid is high and path_ready is low.

    localparam int SUM_W = DATA_W + 2;
    localparam logic [SUM_W-1:0] HALF = SUM_W'(1) << (SIGMA_W - 1);
    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [15:0]       lfsr_q;
    logic [DATA_W-1:0] s0_q;
    logic [7:0]        drift_q;
    logic [PATH_W-1:0] paths_q;
    logic [STEP_W-1:0] steps_q;
    logic [STEP_W-1:0] step_cnt;
    logic [PATH_W-1:0] path_cnt;
    logic [DATA_W-1:0] path_q;
    logic              last_q;
`ifdef PATH_GEN_ANTITHETIC_EN
    logic [15:0]       saved_q;
    logic              calc_save;
`endif

    logic              hs;
    logic              at_last_step;
    logic              at_last_path;
    logic              wrap;
    logic              advance;
    logic              calc_en;
    logic [DATA_W-1:0] calc_prev;
    logic [15:0]       calc_src;
    logic              calc_neg;
    logic              next_last;
    logic [15:0]       lfsr_adv;
    logic [SUM_W-1:0]  delta_raw;
    logic [SUM_W-1:0]  delta_ext;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] calc_sample;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic [15:0] shifted;
        shifted = {1'b0, x[15:1]};
        return x[0] ? (shifted ^ 16'hB400) : shifted;
    endfunction

    assign hs           = (state == S_RUN) && path_ready;
    assign at_last_step = (step_cnt == steps_q - STEP_W'(1));
    assign at_last_path = (path_cnt == paths_q - PATH_W'(1));
    assign wrap         = hs && at_last_step && !at_last_path;
    assign advance      = hs && !at_last_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_paths == '0 || num_steps == '0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            S_LOAD: state_next = S_RUN;
            S_RUN: begin
                if (hs && at_last_step && at_last_path) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Select where the next sample comes from: s0 at a path start, else the presented sample.
    always_comb begin
        calc_en   = 1'b0;
        calc_prev = s0_q;
        calc_src  = lfsr_q;
        calc_neg  = 1'b0;
        next_last = 1'b0;
`ifdef PATH_GEN_ANTITHETIC_EN
        calc_save = 1'b0;
`endif
        if (state == S_LOAD) begin
            calc_en   = 1'b1;
            next_last = (steps_q == STEP_W'(1));
`ifdef PATH_GEN_ANTITHETIC_EN
            calc_save = 1'b1;
`endif
        end else if (wrap) begin
            calc_en   = 1'b1;
            next_last = (steps_q == STEP_W'(1));
`ifdef PATH_GEN_ANTITHETIC_EN
            if (!path_cnt[0]) begin
                calc_src = saved_q;
                calc_neg = 1'b1;
            end else begin
                calc_save = 1'b1;
            end
`endif
        end else if (advance) begin
            calc_en   = 1'b1;
            calc_prev = path_q;
            next_last = (step_cnt + STEP_W'(1) == steps_q - STEP_W'(1));
`ifdef PATH_GEN_ANTITHETIC_EN
            calc_neg = path_cnt[0];
`endif
        end
    end

    // Two's-complement arithmetic in SUM_W bits; the top bit marks a negative sum.
    always_comb begin
        lfsr_adv  = lfsr_step(calc_src);
        delta_raw = {{(SUM_W - SIGMA_W){1'b0}}, lfsr_adv[SIGMA_W-1:0]} - HALF;
        delta_ext = calc_neg ? (~delta_raw + SUM_W'(1)) : delta_raw;
        sum       = {2'b00, calc_prev} + {{(SUM_W - 8){drift_q[7]}}, drift_q} + delta_ext;
        if (sum[SUM_W-1]) begin
            calc_sample = '0;
        end else if (sum[DATA_W]) begin
            calc_sample = '1;
        end else begin
            calc_sample = sum[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q   <= SEED_DEFAULT;
            s0_q     <= '0;
            drift_q  <= '0;
            paths_q  <= '0;
            steps_q  <= '0;
            step_cnt <= '0;
            path_cnt <= '0;
            path_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                lfsr_q   <= (seed == 16'h0000) ? SEED_DEFAULT : seed;
                s0_q     <= s0;
                drift_q  <= drift;
                paths_q  <= num_paths;
                steps_q  <= num_steps;
                step_cnt <= '0;
                path_cnt <= '0;
            end
            if (calc_en) begin
                lfsr_q <= lfsr_adv;
                path_q <= calc_sample;
                last_q <= next_last;
            end
            if (wrap) begin
                path_cnt <= path_cnt + PATH_W'(1);
                step_cnt <= '0;
            end else if (advance) begin
                step_cnt <= step_cnt + STEP_W'(1);
            end
        end
    end

`ifdef PATH_GEN_ANTITHETIC_EN
    // The pre-advance state is kept so the odd partner replays the same deltas, mirrored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            saved_q <= '0;
        end else if (calc_en && calc_save) begin
            saved_q <= calc_src;
        end
    end
`endif

    assign path       = path_q;
    assign path_last  = last_q;
    assign path_valid = (state == S_RUN);
    assign busy       = (state == S_LOAD) || (state == S_RUN);
    assign done       = (state == S_DONE);

endmodule

// File: tb/tb_path_gen.sv
// Directed self-checking bench for path_gen: basic walk, saturation, backpressure, path wrap,
// zero-length / ignored start, and reset in the middle of a batch.
module tb_path_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] seed;
    logic [11:0] s0;
    logic [7:0]  drift;
    logic [15:0] num_paths;
    logic [9:0]  num_steps;
    logic [11:0] path;
    logic        path_valid;
    logic        path_ready;
    logic        path_last;
    logic        busy;
    logic        done;

    int tests;
    int fails;
    logic [11:0] got_path[16];
    logic        got_last[16];

    path_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .s0        (s0),
        .drift     (drift),
        .num_paths (num_paths),
        .num_steps (num_steps),
        .path      (path),
        .path_valid(path_valid),
        .path_ready(path_ready),
        .path_last (path_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_start(input logic [15:0] sd, input logic [11:0] p0, input logic [7:0] dr,
                               input logic [15:0] np, input logic [9:0] ns);
        @(negedge clk);
        seed      = sd;
        s0        = p0;
        drift     = dr;
        num_paths = np;
        num_steps = ns;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Records n samples starting with the one presented now; ready held high throughout.
    task automatic collect(input int n);
        int got;
        int budget;
        got    = 0;
        budget = 0;
        for (int i = 0; i < 16; i++) begin
            got_path[i] = 'x;
            got_last[i] = 1'bx;
        end
        path_ready = 1'b1;
        while (got < n && budget <= 100) begin
            if (path_valid === 1'b1) begin
                got_path[got] = path;
                got_last[got] = path_last;
                got++;
            end
            if (got < n) begin
                @(negedge clk);
                budget++;
            end
        end
        if (got < n) begin
            tests++;
            fails++;
            $display("FAIL collect_timeout: got %0d samples, required %0d", got, n);
        end
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        start      = 1'b0;
        path_ready = 1'b1;
        seed       = '0;
        s0         = '0;
        drift      = '0;
        num_paths  = '0;
        num_steps  = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({path, path_valid, path_last, busy, done} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_outputs: got path=%0d valid=%b last=%b busy=%b done=%b, required all 0",
                     path, path_valid, path_last, busy, done);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({path_valid, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL reset_idle: got valid=%b busy=%b done=%b, required 0 0 0", path_valid, busy, done);
        end
    endtask

    task automatic test_basic;
        logic [11:0] exp_q[$];
        exp_q = '{12'd968, 12'd936, 12'd904, 12'd872, 12'd840, 12'd840};
        pulse_start(16'd1, 12'd1000, 8'd0, 16'd1, 10'd6);
        tests++;
        if (path_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_load_cycle: got valid=%b busy=%b, required 0 1", path_valid, busy);
        end
        @(negedge clk);
        tests++;
        if (path_valid !== 1'b1) begin
            fails++;
            $display("FAIL basic_latency: got valid=%b two cycles after start, required 1", path_valid);
        end
        collect(6);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (got_path[i] !== exp_q[i] || got_last[i] !== (i == 5)) begin
                fails++;
                $display("FAIL basic_sample[%0d]: got %0d last=%b, required %0d last=%b",
                         i, got_path[i], got_last[i], exp_q[i], (i == 5));
            end
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || path_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: got done=%b valid=%b busy=%b, required 1 0 0", done, path_valid, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_pulse: got done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_saturation;
        pulse_start(16'd1, 12'd10, 8'h9C, 16'd1, 10'd3);
        collect(3);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_path[i] !== 12'd0) begin
                fails++;
                $display("FAIL sat_low[%0d]: got %0d, required 0", i, got_path[i]);
            end
        end
        repeat (2) @(negedge clk);
        pulse_start(16'd1, 12'd4090, 8'd127, 16'd1, 10'd3);
        collect(3);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_path[i] !== 12'd4095) begin
                fails++;
                $display("FAIL sat_high[%0d]: got %0d, required 4095", i, got_path[i]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [11:0] exp_q[$];
        exp_q = '{12'd936, 12'd904, 12'd872, 12'd840, 12'd840};
        pulse_start(16'd1, 12'd1000, 8'd0, 16'd1, 10'd6);
        collect(1);
        @(negedge clk);
        path_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (path !== 12'd936 || path_valid !== 1'b1 || path_last !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got path=%0d valid=%b last=%b, required 936 1 0",
                         k, path, path_valid, path_last);
            end
            @(negedge clk);
        end
        collect(5);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (got_path[i] !== exp_q[i] || got_last[i] !== (i == 4)) begin
                fails++;
                $display("FAIL bp_sample[%0d]: got %0d last=%b, required %0d last=%b",
                         i, got_path[i], got_last[i], exp_q[i], (i == 4));
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_path_wrap;
        logic [11:0] exp_q[$];
`ifdef PATH_GEN_ANTITHETIC_EN
        exp_q = '{12'd968, 12'd936, 12'd904, 12'd1032, 12'd1064, 12'd1096};
`else
        exp_q = '{12'd968, 12'd936, 12'd904, 12'd968, 12'd936, 12'd936};
`endif
        pulse_start(16'd1, 12'd1000, 8'd0, 16'd2, 10'd3);
        collect(6);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (got_path[i] !== exp_q[i] || got_last[i] !== (i == 2 || i == 5)) begin
                fails++;
                $display("FAIL wrap_sample[%0d]: got %0d last=%b, required %0d last=%b",
                         i, got_path[i], got_last[i], exp_q[i], (i == 2 || i == 5));
            end
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL wrap_done: got done=%b, required 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_and_ignored;
        logic [11:0] exp_q[$];
        int seen_valid;
        exp_q = '{12'd904, 12'd872, 12'd840, 12'd840};
        pulse_start(16'd1, 12'd1000, 8'd0, 16'd1, 10'd0);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_steps_done: got done=%b busy=%b, required 1 0", done, busy);
        end
        seen_valid = 0;
        repeat (4) begin
            @(negedge clk);
            if (path_valid !== 1'b0) seen_valid++;
        end
        tests++;
        if (seen_valid != 0) begin
            fails++;
            $display("FAIL zero_steps_valid: got %0d valid cycles, required 0", seen_valid);
        end
        pulse_start(16'd1, 12'd1000, 8'd0, 16'd0, 10'd5);
        tests++;
        if (done !== 1'b1 || path_valid !== 1'b0) begin
            fails++;
            $display("FAIL zero_paths_done: got done=%b valid=%b, required 1 0", done, path_valid);
        end
        repeat (2) @(negedge clk);
        pulse_start(16'd1, 12'd1000, 8'd0, 16'd1, 10'd6);
        collect(2);
        seed      = 16'h00FF;
        s0        = 12'd5;
        num_steps = 10'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect(4);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got_path[i] !== exp_q[i] || got_last[i] !== (i == 3)) begin
                fails++;
                $display("FAIL ignored_start[%0d]: got %0d last=%b, required %0d last=%b",
                         i, got_path[i], got_last[i], exp_q[i], (i == 3));
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        logic [11:0] exp_q[$];
        exp_q = '{12'd968, 12'd936, 12'd904, 12'd872, 12'd840, 12'd840};
        pulse_start(16'd1, 12'd1000, 8'd0, 16'd1, 10'd6);
        collect(2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if ({path, path_valid, path_last, busy, done} !== 16'h0000) begin
            fails++;
            $display("FAIL midrun_reset: got path=%0d valid=%b last=%b busy=%b done=%b, required all 0",
                     path, path_valid, path_last, busy, done);
        end
        pulse_start(16'd1, 12'd1000, 8'd0, 16'd1, 10'd6);
        collect(6);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (got_path[i] !== exp_q[i] || got_last[i] !== (i == 5)) begin
                fails++;
                $display("FAIL midrun_restart[%0d]: got %0d last=%b, required %0d last=%b",
                         i, got_path[i], got_last[i], exp_q[i], (i == 5));
            end
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL midrun_done: got done=%b, required 1", done);
        end
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_path_wrap();
        test_zero_and_ignored();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
